// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings and stall-bus width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  // Stall bus carries the PC hold bit plus one hold bit per stage.
  function automatic int stall_w(input int num_stages);
    return num_stages + 1;
  endfunction

endpackage

// File: rtl/stall_prio_enc.sv
// Highest-index priority mask: every bit at or below stage k+1 (plus PC hold) is set
// when k is the highest stage requesting a stall.
module stall_prio_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5
) (
  input  logic [NUM_STAGES-1:0]            stallreq,
  output logic [stall_w(NUM_STAGES)-1:0]   stall_mask
);

  logic acc;

  // Sweep from the oldest stage down; once any stage asks, everything younger holds.
  always_comb begin
    acc        = 1'b0;
    stall_mask = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc             = acc | stallreq[i];
      stall_mask[i+1] = acc;
    end
    stall_mask[0] = acc;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a sticky stall watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_STAGES-1:0]          stallreq,
  input  logic                           flush_req,
  input  logic [31:0]                    flush_pc,
  output logic [stall_w(NUM_STAGES)-1:0] stall,
  output logic                           flush,
  output logic [31:0]                    new_pc,
  output logic                           stall_timeout,
  output logic [1:0]                     ctrl_state,
  output logic [31:0]                    perf_stall_cycles,
  output logic [31:0]                    perf_flush_count
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

  logic [stall_w(NUM_STAGES)-1:0] stall_mask;

  ctrl_state_e     state_q, state_d;
  logic            flush_q, flush_d;
  logic [31:0]     new_pc_q, new_pc_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            stall_any;

  stall_prio_enc #(.NUM_STAGES(NUM_STAGES)) u_enc (
    .stallreq   (stallreq),
    .stall_mask (stall_mask)
  );

  // Holds are released while the flush pulse is out so the redirect can propagate.
  assign stall     = (rst || state_q == ST_FLUSH) ? '0 : stall_mask;
  assign stall_any = |stall;

  always_comb begin
    state_d   = ST_RUN;
    flush_d   = flush_req;
    new_pc_d  = flush_req ? flush_pc : new_pc_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (flush_req)      state_d = ST_FLUSH;
    else if (stall_any) state_d = ST_STALL;
    if (!stall_any || flush_q)  wd_cnt_d = '0;
    else if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
    if (wd_cnt_d == WD_MAX) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign ctrl_state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_any};
    perf_flush_d = perf_flush_q + {31'd0, flush_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (NUM_STAGES=5, STALL_TIMEOUT=4): vector table plus corner sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.NUM_STAGES(5), .STALL_TIMEOUT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq          (stallreq),
    .flush_req         (flush_req),
    .flush_pc          (flush_pc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (stall_timeout),
    .ctrl_state        (ctrl_state),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_req = 1'b0; stallreq = '0; flush_pc = '0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] req;
    logic [5:0] exp_stall;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] exp_perf_stall, exp_perf_flush;

  initial begin
    vecs[0] = '{5'b00000, 6'b000000, 2'd0};
    vecs[1] = '{5'b00001, 6'b000011, 2'd1};
    vecs[2] = '{5'b00010, 6'b000111, 2'd1};
    vecs[3] = '{5'b00110, 6'b001111, 2'd1};
    vecs[4] = '{5'b10000, 6'b111111, 2'd1};
    vecs[5] = '{5'b01001, 6'b011111, 2'd1};
    vecs[6] = '{5'b00100, 6'b001111, 2'd1};
    vecs[7] = '{5'b00000, 6'b000000, 2'd0};

    // Reset values, with a stall request present during the reset cycle
    rst = 1'b1; flush_req = 1'b1; flush_pc = 32'hDEAD_BEEF; stallreq = 5'b00010;
    #1;
    check("stall_in_reset", {26'd0, stall}, 32'd0);
    tick();
    check("rst_state", {30'd0, ctrl_state}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_new_pc", new_pc, 32'd0);
    check("rst_timeout", {31'd0, stall_timeout}, 32'd0);
    check("rst_perf_stall", perf_stall_cycles, 32'd0);
    check("rst_perf_flush", perf_flush_count, 32'd0);
    do_reset();

    // Combinational priority mask and next FSM state
    for (int i = 0; i < 8; i++) begin
      stallreq = vecs[i].req;
      #1;
      check($sformatf("vec%0d_stall", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      tick();
      check($sformatf("vec%0d_state", i), {30'd0, ctrl_state}, {30'd0, vecs[i].exp_state});
    end

    // Flush during a stall request: pulse, target, and forced-zero stall
    do_reset();
    stallreq = 5'b00100; flush_req = 1'b1; flush_pc = 32'hBFC0_0380;
    #1;
    check("stall_before_flush", {26'd0, stall}, 32'h0000_000F);
    tick();
    flush_req = 1'b0; flush_pc = 32'h1234_5678;
    check("flush_pulse", {31'd0, flush}, 32'd1);
    check("flush_pc", new_pc, 32'hBFC0_0380);
    check("flush_stall_forced", {26'd0, stall}, 32'd0);
    check("flush_state", {30'd0, ctrl_state}, 32'd2);
    tick();
    check("flush_one_cycle", {31'd0, flush}, 32'd0);
    check("new_pc_held", new_pc, 32'hBFC0_0380);
    check("stall_after_flush", {26'd0, stall}, 32'h0000_000F);

    // Back-to-back flush requests
    do_reset();
    flush_req = 1'b1; flush_pc = 32'h100;
    tick();
    flush_pc = 32'h200;
    check("b2b_flush1", {31'd0, flush}, 32'd1);
    check("b2b_pc1", new_pc, 32'h100);
    tick();
    flush_req = 1'b0; flush_pc = 32'h300;
    check("b2b_flush2", {31'd0, flush}, 32'd1);
    check("b2b_pc2", new_pc, 32'h200);
    tick();
    check("b2b_end", {31'd0, flush}, 32'd0);
    check("b2b_pc_hold", new_pc, 32'h200);

    // Watchdog: stall held 6 cycles, flag rises once the count hits 4, and is sticky
    do_reset();
    stallreq = 5'b00100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("wd_cycle%0d", c), {31'd0, stall_timeout}, (c >= 4) ? 32'd1 : 32'd0);
    end
    stallreq = '0;
    tick(); tick();
    check("wd_sticky", {31'd0, stall_timeout}, 32'd1);
    do_reset();
    #1;
    check("wd_cleared_by_rst", {31'd0, stall_timeout}, 32'd0);

    // Reset mid-stall with a coincident flush request
    stallreq = 5'b00100;
    tick(); tick();
    rst = 1'b1; flush_req = 1'b1; flush_pc = 32'hCAFE_0000;
    tick();
    check("midrst_state", {30'd0, ctrl_state}, 32'd0);
    check("midrst_flush", {31'd0, flush}, 32'd0);
    check("midrst_new_pc", new_pc, 32'd0);
    check("midrst_stall", {26'd0, stall}, 32'd0);
    rst = 1'b0; flush_req = 1'b0; stallreq = '0;
    tick();
    check("midrst_no_pulse", {31'd0, flush}, 32'd0);

    // Performance counters: 3 stall cycles then 2 separate flushes
    do_reset();
    stallreq = 5'b00001;
    tick(); tick(); tick();
    stallreq = '0; flush_req = 1'b1; flush_pc = 32'h40;
    tick();
    flush_req = 1'b0;
    tick();
    flush_req = 1'b1; flush_pc = 32'h80;
    tick();
    flush_req = 1'b0;
    tick(); tick();
`ifdef PIPE_CTRL_PERF_EN
    exp_perf_stall = 32'd3;
    exp_perf_flush = 32'd2;
`else
    exp_perf_stall = 32'd0;
    exp_perf_flush = 32'd0;
`endif
    check("perf_stall_cycles", perf_stall_cycles, exp_perf_stall);
    check("perf_flush_count", perf_flush_count, exp_perf_flush);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages (IF=0 ... WB=NUM_STAGES-1); legal range 2..16.
REQ-002 SHALL have parameter STALL_TIMEOUT, default 1024, stall-watchdog threshold in cycles; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stallreq  input  NUM_STAGES  bit j = stall request from stage j.
REQ-006 SHALL have port flush_req  input  1  one-cycle flush request (exception/redirect).
REQ-007 SHALL have port flush_pc  input  32  redirect target, sampled with flush_req.
REQ-008 SHALL have port stall  output  NUM_STAGES+1  bit 0 = PC hold, bit j+1 = stage-j register hold.
REQ-009 SHALL have port flush  output  1  registered one-cycle flush pulse to all stages.
REQ-010 SHALL have port new_pc  output  32  redirect target, valid while flush=1.
REQ-011 SHALL have port stall_timeout  output  1  sticky watchdog flag.
REQ-012 SHALL have port ctrl_state  output  2  FSM state (RUN=0, STALL=1, FLUSH=2).
REQ-013 SHALL have ports perf_stall_cycles and perf_flush_count  output  32 each  performance counters (see Configuration).

Function
REQ-014 stall SHALL be combinational: k = highest j with stallreq[j]=1; stall[k+1:0]=all ones, stall[NUM_STAGES:k+2]=0; stall=0 when stallreq=0.
REQ-015 The bubble SHALL be implied at stage k+1 (stall[k+1]=1, stall[k+2]=0); pipe_ctrl SHALL NOT generate a separate bubble signal.
REQ-016 While ctrl_state=FLUSH, stall SHALL be forced to 0 regardless of stallreq.
REQ-017 flush_req=1 in cycle t SHALL produce flush=1 and new_pc=flush_pc(t) in cycle t+1, flush=1 for exactly one cycle per accepted request.
REQ-018 new_pc SHALL hold its last captured value when flush=0.
REQ-019 flush_req SHALL be accepted in every state, including FLUSH (back-to-back requests give back-to-back pulses, each with its own target) and STALL (stall persists in cycle t, flush in t+1).
REQ-020 FSM next state: flush_req -> FLUSH; else stall!=0 -> STALL; else RUN; flush_req has priority over stallreq.
REQ-021 Watchdog counter SHALL increment each cycle stall!=0, clear when stall=0 or flush=1, and saturate at STALL_TIMEOUT; width clog2(STALL_TIMEOUT+1).
REQ-022 stall_timeout SHALL set in the cycle after the counter reaches STALL_TIMEOUT and remain 1 until rst.
REQ-023 Latency: stall 0 cycles; flush/new_pc 1 cycle; stall_timeout 1 cycle after threshold.

Reset
REQ-024 On rst: ctrl_state=RUN, flush=0, new_pc=0, watchdog=0, stall_timeout=0, perf counters=0; stall=0 during the reset cycle.
REQ-025 A flush_req coincident with rst SHALL be discarded.

Configuration
REQ-026 Macro PIPE_CTRL_PERF_EN defined: perf_stall_cycles counts cycles with stall!=0, perf_flush_count counts flush pulses, both 32-bit wrapping, cleared only by rst.
REQ-027 Macro PIPE_CTRL_PERF_EN undefined: both perf outputs tied to 0, no counter flops synthesised.

Structure
REQ-028 Shared package (pipe_ctrl_pkg) SHALL hold state encodings (RUN/STALL/FLUSH) and the stall-bus width expression NUM_STAGES+1.
REQ-029 One sub-module, stall_prio_enc, SHALL implement the REQ-014 highest-index priority mask; all sequential logic stays in pipe_ctrl.

Verification (NUM_STAGES=5, STALL_TIMEOUT=4)
REQ-030 stallreq=5'b00010 -> stall=6'b000111, ctrl_state=STALL next cycle; stallreq=5'b00110 -> stall=6'b001111.
REQ-031 flush_req=1, flush_pc=0xBFC00380 at t -> flush=1, new_pc=0xBFC00380 at t+1 only; stall=0 at t+1 despite stallreq=5'b00100.
REQ-032 flush_req at t (pc 0x100) and t+1 (pc 0x200) -> flush=1 at t+1 and t+2 with new_pc 0x100 then 0x200.
REQ-033 stallreq=5'b00100 held 6 cycles -> stall_timeout rises after cycle 4 and stays 1 after stallreq drops; clears only on rst.
REQ-034 rst asserted mid-stall with flush_req=1 -> next cycle all outputs at reset values, no flush pulse.
REQ-035 With PIPE_CTRL_PERF_EN: 3 stall cycles + 2 flushes -> perf_stall_cycles=3, perf_flush_count=2; without the macro both read 0.
